// File: rtl/h2c_chk_pkg.sv
// ---------------------------------------------------------------------------
// h2c_chk_pkg
// Shared types and constants for the H2C streaming data checker.
//   state_t        : controller states (IDLE, SOP, MID)
//   LFSR_SEED/TAPS : backpressure LFSR constants, used only when the
//                    H2C_CHK_BP_EN macro is defined
//   lane_expected  : expected pattern value for one lane of one beat
// ---------------------------------------------------------------------------
package h2c_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SOP  = 2'd1,
      MID  = 2'd2
   } state_t;

   // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Untruncated expected value b*LANES + i; the caller keeps the low
   // PATT_WIDTH bits, which gives the silent wrap of the pattern.
   function automatic logic [31:0] lane_expected(input logic [31:0]   beat,
                                                 input int unsigned   lanes,
                                                 input int unsigned   lane);
      return beat * lanes + lane;
   endfunction

endpackage

// File: rtl/h2c_chk_lanes.sv
// ---------------------------------------------------------------------------
// h2c_chk_lanes
// Combinational per-lane compare of one H2C beat against the incrementing
// pattern. A lane whose keep byte is clear always matches.
// Ports:
//   tdata  in  DATA_WIDTH      beat data
//   tkeep  in  DATA_WIDTH/8    byte valid; first byte of each lane qualifies it
//   beat   in  32              beat index within the packet
//   match  out LANES           per-lane match vector
// ---------------------------------------------------------------------------
module h2c_chk_lanes #(
   parameter int DATA_WIDTH = 512,
   parameter int PATT_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0]              tdata,
   input  logic [DATA_WIDTH/8-1:0]            tkeep,
   input  logic [31:0]                        beat,
   output logic [DATA_WIDTH/PATT_WIDTH-1:0]   match
);
   import h2c_chk_pkg::*;

   localparam int LANES = DATA_WIDTH / PATT_WIDTH;

   // Only the first keep byte of each lane is looked at; the rest are
   // collected here so they are visibly consumed.
   logic unused_keep;
   assign unused_keep = ^tkeep;

   // One comparator per lane, each against its own pattern value
   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic [PATT_WIDTH-1:0] exp_lane;
         logic                  lane_keep;
         assign exp_lane  = PATT_WIDTH'(lane_expected(beat, LANES, i));
         assign lane_keep = tkeep[i*PATT_WIDTH/8];
         assign match[i]  = ~lane_keep |
                            (tdata[i*PATT_WIDTH +: PATT_WIDTH] == exp_lane);
      end
   endgenerate

endmodule

// File: rtl/h2c_chk_ctrl.sv
// ---------------------------------------------------------------------------
// h2c_chk_ctrl
// Sink-side controller of the H2C streaming data checker. Accepts the AXI-ST
// H2C stream, checks each beat against the incrementing pattern, sequences
// packet boundaries and keeps packet/error statistics.
// Optional feature: define H2C_CHK_BP_EN to throttle tready with a 16-bit
// LFSR while running (source backpressure exercise).
// Ports:
//   axi_aclk, axi_aresetn   clock, asynchronous active-low reset
//   ctrl_run                checker enable (level)
//   ctrl_clr                pulse, clears statistics and sticky error
//   s_axis_*                H2C AXI-ST sink (tdata/tkeep/tlast/tuser_qid/
//                           tvalid in, tready out)
//   pkt_done, pkt_ok        per-packet result pulse and its qualifier
//   err_sticky, err_qid     first-error flag and the qid that caused it
//   pkt_cnt, err_pkt_cnt    saturating packet / errored-packet counters
// ---------------------------------------------------------------------------
module h2c_chk_ctrl #(
   parameter int DATA_WIDTH = 512,
   parameter int PATT_WIDTH = 16,
   parameter int QID_WIDTH  = 11,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                     axi_aclk,
   input  logic                     axi_aresetn,
   input  logic                     ctrl_run,
   input  logic                     ctrl_clr,
   input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic                     s_axis_tlast,
   input  logic [QID_WIDTH-1:0]     s_axis_tuser_qid,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   output logic                     pkt_done,
   output logic                     pkt_ok,
   output logic                     err_sticky,
   output logic [QID_WIDTH-1:0]     err_qid,
   output logic [CNT_WIDTH-1:0]     pkt_cnt,
   output logic [CNT_WIDTH-1:0]     err_pkt_cnt
);
   import h2c_chk_pkg::*;

   localparam int LANES = DATA_WIDTH / PATT_WIDTH;

   state_t                 state;
   state_t                 state_nxt;
   logic                   at_boundary;
   logic [31:0]            beat_cnt;
   logic [QID_WIDTH-1:0]   pkt_qid;
   logic                   ready_en;
   logic                   accept;
   logic                   checking;
   logic                   is_sop;
   logic [LANES-1:0]       lane_match;

   logic                   s1_valid;
   logic                   s1_last;
   logic [LANES-1:0]       s1_match;
   logic [QID_WIDTH-1:0]   s1_qid;

   logic                   pkt_err_acc;
   logic                   beat_ok;
   logic                   pkt_close;
   logic                   pkt_bad;

   assign accept   = s_axis_tvalid & s_axis_tready;
   assign checking = accept & (state != IDLE);
   assign is_sop   = (state == SOP);

   // tready stays low while in reset and rises on the first clock after it,
   // so every output reads 0 during reset.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) ready_en <= 1'b0;
      else              ready_en <= 1'b1;
   end

`ifdef H2C_CHK_BP_EN
   logic [15:0] lfsr;

   // Free-running LFSR; its low bit stalls the stream on roughly half of
   // the cycles, but only while the checker is running.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) lfsr <= LFSR_SEED;
      else              lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   assign s_axis_tready = ready_en & (~lfsr[0] | ~ctrl_run);
`else
   assign s_axis_tready = ready_en;
`endif

   // Remembers whether the stream sits between packets: true out of reset,
   // then tracks tlast of every accepted beat, checked or not.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)  at_boundary <= 1'b1;
      else if (accept)   at_boundary <= s_axis_tlast;
   end

   // Next-state logic. IDLE only arms at a packet boundary; a beat accepted
   // in the arming cycle counts, so a non-last beat keeps us in IDLE.
   // Dropping ctrl_run lets a packet in progress finish before IDLE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (ctrl_run && (accept ? s_axis_tlast : at_boundary))
               state_nxt = SOP;
         end
         SOP: begin
            if (accept) begin
               if (!s_axis_tlast)  state_nxt = MID;
               else if (!ctrl_run) state_nxt = IDLE;
            end else if (!ctrl_run) begin
               state_nxt = IDLE;
            end
         end
         MID: begin
            if (accept && s_axis_tlast)
               state_nxt = ctrl_run ? SOP : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) state <= IDLE;
      else              state <= state_nxt;
   end

   // Beat index within the packet; zero whenever a packet is about to start,
   // so the SOP beat is always checked as beat 0.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)        beat_cnt <= 32'd0;
      else if (state == IDLE)  beat_cnt <= 32'd0;
      else if (checking)       beat_cnt <= s_axis_tlast ? 32'd0 : beat_cnt + 32'd1;
   end

   // Packet qid, taken from the first beat
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)         pkt_qid <= '0;
      else if (checking && is_sop) pkt_qid <= s_axis_tuser_qid;
   end

   h2c_chk_lanes #(
      .DATA_WIDTH (DATA_WIDTH),
      .PATT_WIDTH (PATT_WIDTH)
   ) u_lanes (
      .tdata (s_axis_tdata),
      .tkeep (s_axis_tkeep),
      .beat  (beat_cnt),
      .match (lane_match)
   );

   // Stage 1: register the lane compare vector with its tlast and qid.
   // The SOP beat carries its own qid since pkt_qid loads in parallel.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_match <= '0;
         s1_qid   <= '0;
      end else begin
         s1_valid <= checking;
         s1_last  <= s_axis_tlast;
         s1_match <= lane_match;
         s1_qid   <= is_sop ? s_axis_tuser_qid : pkt_qid;
      end
   end

   assign beat_ok   = &s1_match;
   assign pkt_close = s1_valid & s1_last;
   assign pkt_bad   = pkt_err_acc | ~beat_ok;

   // Stage 2: fold each beat into the packet error flag and emit the
   // per-packet result. ctrl_clr does not touch this path, so packets
   // already in flight still report.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         pkt_err_acc <= 1'b0;
         pkt_done    <= 1'b0;
         pkt_ok      <= 1'b0;
      end else begin
         pkt_done <= pkt_close;
         pkt_ok   <= pkt_close & ~pkt_bad;
         if (s1_valid)
            pkt_err_acc <= s1_last ? 1'b0 : pkt_bad;
      end
   end

   // Statistics, updated on the same edge that raises pkt_done. Clear has
   // priority over a concurrent packet close; counters saturate.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         pkt_cnt     <= '0;
         err_pkt_cnt <= '0;
         err_sticky  <= 1'b0;
         err_qid     <= '0;
      end else if (ctrl_clr) begin
         pkt_cnt     <= '0;
         err_pkt_cnt <= '0;
         err_sticky  <= 1'b0;
         err_qid     <= '0;
      end else begin
         if (pkt_close && (pkt_cnt != '1))
            pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
         if (pkt_close && pkt_bad && (err_pkt_cnt != '1))
            err_pkt_cnt <= err_pkt_cnt + CNT_WIDTH'(1);
         if (s1_valid && !beat_ok && !err_sticky) begin
            err_sticky <= 1'b1;
            err_qid    <= s1_qid;
         end
      end
   end

endmodule
